// File: rtl/mult_arbiter.sv
// mult_arbiter: round-robin front end sharing one sign-magnitude sequential
// multiplier between two requesters, with a RUN-cycle timeout abort.
module mult_arbiter #(
  parameter int unsigned TIMEOUT = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req_valid,
  input  logic [7:0]  req_a0,
  input  logic [7:0]  req_b0,
  input  logic [7:0]  req_a1,
  input  logic [7:0]  req_b1,
  output logic [1:0]  req_ready,
  output logic [1:0]  rsp_valid,
  output logic [15:0] rsp_data,
  output logic        rsp_err,
  input  logic [1:0]  rsp_ready,
  output logic        busy,
  output logic        mult_start,
  output logic [7:0]  mult_multiplier,
  output logic [7:0]  mult_multiplicand,
  input  logic        mult_done,
  input  logic [14:0] mult_product,
  input  logic        mult_sign
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  localparam int unsigned RES_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t           state;
  state_t           state_next;
  logic             grant;
  logic             last_grant;
  logic [CNT_W-1:0] cnt;
  logic             grant_c;
  logic             take_c;
  logic             done_c;
  logic             abort_c;
  logic             release_c;
  logic [RES_W-1:0] mag_c;
  logic [RES_W-1:0] result_c;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next state, round-robin pick and the combinational accept pulse
  always_comb begin
    state_next = state;
    take_c     = 1'b0;
    done_c     = 1'b0;
    abort_c    = 1'b0;
    release_c  = 1'b0;
    req_ready  = 2'b00;
    grant_c    = (req_valid == 2'b11) ? ~last_grant : req_valid[1];
    case (state)
      IDLE: begin
        if (!rst && (req_valid != 2'b00)) begin
          take_c     = 1'b1;
          req_ready  = grant_c ? 2'b10 : 2'b01;
          state_next = LOAD;
        end
      end
      LOAD: state_next = RUN;
      RUN: begin
        if (mult_done) begin
          done_c     = 1'b1;
          state_next = RESP;
        end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
          abort_c    = 1'b1;
          state_next = RESP;
        end
      end
      RESP: begin
        if (rsp_ready[grant]) begin
          release_c  = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Sign-magnitude to two's complement; a zero magnitude stays zero
  always_comb begin
    mag_c    = {1'b0, mult_product};
    result_c = mult_sign ? (~mag_c + RES_W'(1)) : mag_c;
  end

  // Operand capture, run counter, response registers and grant history
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant             <= 1'b0;
      last_grant        <= 1'b1;
      cnt               <= '0;
      mult_start        <= 1'b0;
      mult_multiplier   <= '0;
      mult_multiplicand <= '0;
      rsp_valid         <= 2'b00;
      rsp_data          <= '0;
      rsp_err           <= 1'b0;
      busy              <= 1'b0;
    end else begin
      mult_start <= 1'b0;
      busy       <= (state_next != IDLE);
      if (take_c) begin
        grant             <= grant_c;
        mult_start        <= 1'b1;
        mult_multiplier   <= grant_c ? req_a1 : req_a0;
        mult_multiplicand <= grant_c ? req_b1 : req_b0;
      end
      if (state == LOAD)     cnt <= '0;
      else if (state == RUN) cnt <= cnt + CNT_W'(1);
      if (done_c) begin
        rsp_data  <= result_c;
        rsp_err   <= 1'b0;
        rsp_valid <= {grant, ~grant};
      end else if (abort_c) begin
        rsp_data  <= '0;
        rsp_err   <= 1'b1;
        rsp_valid <= {grant, ~grant};
      end
      if (release_c) begin
        rsp_valid  <= 2'b00;
        last_grant <= grant;
      end
    end
  end

endmodule
